// File: rtl/wm_cycle_sequencer.sv
// Washing-machine programme sequencer for one machine.
// Snapshots the programmed durations on start, then runs
// FILL -> WASH -> DRAIN -> RINSE -> SPIN -> DONE, one time unit per tick.
// Optional build macro WM_DOOR_INTERLOCK_EN: an open door blocks start in
// IDLE and freezes progress in active phases, like pause.
//
// state | meaning
// IDLE  | waiting for start, actuators off, door unlocked
// FILL  | water valve open for the load-dependent fill time
// WASH  | drum turning
// DRAIN | pump emptying the drum (also the abort path)
// RINSE | valve open and drum turning
// SPIN  | drum fast with pump running
// DONE  | programme finished, waiting for ack
module wm_cycle_sequencer #(
  parameter int TICK_DIV    = 4,
  parameter int DRAIN_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] wash_set,
  input  logic [4:0] rinse_set,
  input  logic [4:0] spin_set,
  input  logic [4:0] cloth_set,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic       ack,
  input  logic       door_open,
  output logic [2:0] state,
  output logic [7:0] remaining,
  output logic       valve_on,
  output logic       motor_on,
  output logic       spin_fast,
  output logic       pump_on,
  output logic       door_lock,
  output logic       done_pulse
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_DRAIN = 3'd3,
    S_RINSE = 3'd4,
    S_SPIN  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  localparam int             PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [4:0]     DRAIN_LEN = 5'(DRAIN_TICKS);

  state_e        state_q, state_d;
  logic [4:0]    wash_q, wash_d, rinse_q, rinse_d, spin_q, spin_d;
  logic [3:0]    fill_q, fill_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [7:0]    rem_q, rem_d;
  logic          aborted_q, aborted_d;
  logic          valve_q, motor_q, spin_fast_q, pump_q, lock_q, done_q;

  logic tick, hold, start_ok;
  logic unused_inputs;

`ifdef WM_DOOR_INTERLOCK_EN
  assign hold          = pause | door_open;
  assign start_ok      = start & ~door_open;
  assign unused_inputs = ^cloth_set[1:0];
`else
  assign hold          = pause;
  assign start_ok      = start;
  assign unused_inputs = ^{cloth_set[1:0], door_open};
`endif

  assign tick = (presc_q == PRESC_MAX);

  // Next-state logic: start/snapshot, abort, pause hold, tick-driven phase advance with zero-length skips.
  always_comb begin
    state_d   = state_q;
    wash_d    = wash_q;
    rinse_d   = rinse_q;
    spin_d    = spin_q;
    fill_d    = fill_q;
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    aborted_d = aborted_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          fill_d    = {1'b0, cloth_set[4:2]} + 4'd1;
          wash_d    = wash_set;
          rinse_d   = rinse_set;
          spin_d    = spin_set;
          state_d   = S_FILL;
          cnt_d     = {1'b0, fill_d};
          presc_d   = '0;
          aborted_d = 1'b0;
          rem_d     = 8'(fill_d) + 8'(wash_set) + 8'(DRAIN_TICKS)
                    + 8'(rinse_set) + 8'(spin_set);
        end
      end
      S_DONE: begin
        if (ack) state_d = S_IDLE;
      end
      default: begin
        if (abort && state_q != S_DRAIN) begin
          state_d   = S_DRAIN;
          cnt_d     = DRAIN_LEN;
          rem_d     = 8'(DRAIN_TICKS);
          presc_d   = '0;
          aborted_d = 1'b1;
        end else if (!hold) begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            rem_d = rem_q - 8'd1;
            if (cnt_q == 5'd1) begin
              case (state_q)
                S_FILL: begin
                  if (wash_q != 5'd0) begin
                    state_d = S_WASH;
                    cnt_d   = wash_q;
                  end else begin
                    state_d = S_DRAIN;
                    cnt_d   = DRAIN_LEN;
                  end
                end
                S_WASH: begin
                  state_d = S_DRAIN;
                  cnt_d   = DRAIN_LEN;
                end
                S_DRAIN: begin
                  if (aborted_q) begin
                    state_d = S_DONE;
                    cnt_d   = 5'd0;
                  end else if (rinse_q != 5'd0) begin
                    state_d = S_RINSE;
                    cnt_d   = rinse_q;
                  end else if (spin_q != 5'd0) begin
                    state_d = S_SPIN;
                    cnt_d   = spin_q;
                  end else begin
                    state_d = S_DONE;
                    cnt_d   = 5'd0;
                  end
                end
                S_RINSE: begin
                  if (spin_q != 5'd0) begin
                    state_d = S_SPIN;
                    cnt_d   = spin_q;
                  end else begin
                    state_d = S_DONE;
                    cnt_d   = 5'd0;
                  end
                end
                default: begin
                  state_d = S_DONE;
                  cnt_d   = 5'd0;
                end
              endcase
            end else begin
              cnt_d = cnt_q - 5'd1;
            end
          end
        end
      end
    endcase
  end

  // State, snapshot and counter registers; actuator outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wash_q      <= '0;
      rinse_q     <= '0;
      spin_q      <= '0;
      fill_q      <= '0;
      presc_q     <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      aborted_q   <= 1'b0;
      valve_q     <= 1'b0;
      motor_q     <= 1'b0;
      spin_fast_q <= 1'b0;
      pump_q      <= 1'b0;
      lock_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wash_q      <= wash_d;
      rinse_q     <= rinse_d;
      spin_q      <= spin_d;
      fill_q      <= fill_d;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      aborted_q   <= aborted_d;
      valve_q     <= (state_d == S_FILL) || (state_d == S_RINSE);
      motor_q     <= (state_d == S_WASH) || (state_d == S_RINSE) || (state_d == S_SPIN);
      spin_fast_q <= (state_d == S_SPIN);
      pump_q      <= (state_d == S_DRAIN) || (state_d == S_SPIN);
      lock_q      <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q      <= (state_d == S_DONE) && (state_q != S_DONE);
    end
  end

  assign state      = state_q;
  assign remaining  = rem_q;
  assign valve_on   = valve_q;
  assign motor_on   = motor_q;
  assign spin_fast  = spin_fast_q;
  assign pump_on    = pump_q;
  assign door_lock  = lock_q;
  assign done_pulse = done_q;

endmodule

// File: tb/tb_wm_cycle_sequencer.sv
// Scoreboard bench for wm_cycle_sequencer (TICK_DIV=4, DRAIN_TICKS=2).
// Stimulus pushes expected state entries (state, remaining, cycle); the
// monitor pops one on every observed state change and checks actuators every cycle.
module tb_wm_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] wash_set = '0, rinse_set = '0, spin_set = '0, cloth_set = '0;
  logic       start = 1'b0, pause = 1'b0, abort = 1'b0, ack = 1'b0, door_open = 1'b0;
  logic [2:0] state;
  logic [7:0] remaining;
  logic       valve_on, motor_on, spin_fast, pump_on, door_lock, done_pulse;

  wm_cycle_sequencer #(.TICK_DIV(4), .DRAIN_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wash_set(wash_set), .rinse_set(rinse_set), .spin_set(spin_set), .cloth_set(cloth_set),
    .start(start), .pause(pause), .abort(abort), .ack(ack), .door_open(door_open),
    .state(state), .remaining(remaining),
    .valve_on(valve_on), .motor_on(motor_on), .spin_fast(spin_fast),
    .pump_on(pump_on), .door_lock(door_lock), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] st;
    logic [7:0] rem;
    int         at;
  } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int st, input int rem, input int at);
    exp_q.push_back('{3'(st), 8'(rem), at});
  endtask

  task automatic at_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic settings(input int cl, input int w, input int r, input int s);
    cloth_set = 5'(cl);
    wash_set  = 5'(w);
    rinse_set = 5'(r);
    spin_set  = 5'(s);
  endtask

  // {valve, motor, spin_fast, pump, door_lock} for each state
  function automatic logic [4:0] exp_act(input logic [2:0] s);
    case (s)
      3'd1:    return 5'b10001;
      3'd2:    return 5'b01001;
      3'd3:    return 5'b00011;
      3'd4:    return 5'b11001;
      3'd5:    return 5'b01111;
      default: return 5'b00000;
    endcase
  endfunction

  // Monitor: per-cycle actuator check, scoreboard pop on every state change.
  logic [2:0] prev_st = 3'd0;
  always @(negedge clk) begin
    ev_t        e;
    logic [5:0] got, want;
    got  = {valve_on, motor_on, spin_fast, pump_on, door_lock, done_pulse};
    want = {exp_act(state), (state == 3'd6) && (prev_st != 3'd6)};
    chk("outputs", int'(got), int'(want));
    if (state != prev_st) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transition: got state %0d, expected no change (cycle %0d)", state, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("entry_state", int'(state), int'(e.st));
        chk("entry_remaining", int'(remaining), int'(e.rem));
        chk("entry_cycle", cyc, e.at);
      end
    end
    prev_st = state;
  end

  task automatic run_skip();
    int c;
    c = cyc;
    settings(0, 0, 0, 0);
    start = 1'b1;
    expect_ev(1, 3, c + 1);
    expect_ev(3, 2, c + 5);
    expect_ev(6, 0, c + 13);
    @(negedge clk);
    start = 1'b0;
    at_cyc(c + 7);
    start = 1'b1;                 // ignored outside IDLE
    @(negedge clk);
    start = 1'b0;
    at_cyc(c + 13);
    ack = 1'b1;
    expect_ev(0, 0, c + 14);
    @(negedge clk);
    ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int c;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", int'(state), 0);
    chk("reset_remaining", int'(remaining), 0);
    chk("reset_flags", int'({valve_on, motor_on, spin_fast, pump_on, door_lock, done_pulse}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full programme: fill 3, wash 2, drain 2, rinse 1, spin 1
    c = cyc;
    settings(8, 2, 1, 1);
    start = 1'b1;
    expect_ev(1, 9, c + 1);
    expect_ev(2, 6, c + 13);
    expect_ev(3, 4, c + 21);
    expect_ev(4, 2, c + 29);
    expect_ev(5, 1, c + 33);
    expect_ev(6, 0, c + 37);
    @(negedge clk);
    start = 1'b0;
    at_cyc(c + 40);
    chk("done_hold", int'(state), 6);
    ack = 1'b1;
    expect_ev(0, 0, c + 41);
    @(negedge clk);
    ack = 1'b0;
    repeat (2) @(negedge clk);

    // Skip all optional phases
    run_skip();

    // Pause 10 clk in WASH: everything after shifts by exactly 10
    c = cyc;
    settings(8, 2, 1, 1);
    start = 1'b1;
    expect_ev(1, 9, c + 1);
    expect_ev(2, 6, c + 13);
    expect_ev(3, 4, c + 31);
    expect_ev(4, 2, c + 39);
    expect_ev(5, 1, c + 43);
    expect_ev(6, 0, c + 47);
    @(negedge clk);
    start = 1'b0;
    at_cyc(c + 15);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("pause_state", int'(state), 2);
      chk("pause_remaining", int'(remaining), 6);
    end
    pause = 1'b0;
    at_cyc(c + 47);
    ack = 1'b1;
    expect_ev(0, 0, c + 48);
    @(negedge clk);
    ack = 1'b0;
    repeat (2) @(negedge clk);

    // Abort (while paused) in RINSE with 5 ticks left; abort in DRAIN ignored
    c = cyc;
    settings(0, 1, 3, 2);
    start = 1'b1;
    expect_ev(1, 9, c + 1);
    expect_ev(2, 8, c + 5);
    expect_ev(3, 7, c + 9);
    expect_ev(4, 5, c + 17);
    expect_ev(3, 2, c + 18);
    expect_ev(6, 0, c + 26);
    @(negedge clk);
    start = 1'b0;
    at_cyc(c + 11);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    at_cyc(c + 17);
    abort = 1'b1;
    pause = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    pause = 1'b0;
    chk("abort_pump", int'(pump_on), 1);
    at_cyc(c + 26);
    ack = 1'b1;
    expect_ev(0, 0, c + 27);
    @(negedge clk);
    ack = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in SPIN, between clock edges
    c = cyc;
    settings(8, 2, 1, 1);
    start = 1'b1;
    expect_ev(1, 9, c + 1);
    expect_ev(2, 6, c + 13);
    expect_ev(3, 4, c + 21);
    expect_ev(4, 2, c + 29);
    expect_ev(5, 1, c + 33);
    expect_ev(0, 0, c + 35);
    @(negedge clk);
    start = 1'b0;
    at_cyc(c + 34);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_state", int'(state), 0);
    chk("async_reset_remaining", int'(remaining), 0);
    chk("async_reset_flags", int'({valve_on, motor_on, spin_fast, pump_on, door_lock, done_pulse}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_skip();

`ifdef WM_DOOR_INTERLOCK_EN
    // Door open blocks start, then freezes FILL for 6 clk
    settings(0, 0, 0, 0);
    door_open = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("door_blocks_start", int'(state), 0);
    start = 1'b0;
    door_open = 1'b0;
    @(negedge clk);
    c = cyc;
    start = 1'b1;
    expect_ev(1, 3, c + 1);
    expect_ev(3, 2, c + 11);
    expect_ev(6, 0, c + 19);
    @(negedge clk);
    start = 1'b0;
    at_cyc(c + 2);
    door_open = 1'b1;
    at_cyc(c + 8);
    door_open = 1'b0;
    at_cyc(c + 19);
    ack = 1'b1;
    expect_ev(0, 0, c + 20);
    @(negedge clk);
    ack = 1'b0;
    repeat (2) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wm_cycle_sequencer.md
Name: wm_cycle_sequencer

Overview:
- Downstream consumer of one washing-machine channel's programmed settings: wash/rinse/spin durations and cloth load.
- Snapshots the settings on a start request, then runs the wash programme FSM: FILL, WASH, DRAIN, RINSE, SPIN, DONE.
- Drives the actuator enables, door lock and remaining-time count.
- One instance per washing machine in the home controller top level.

Parameters:
- TICK_DIV, 4: clk cycles per time unit (tick). Legal range ≥2.
- DRAIN_TICKS, 2: fixed DRAIN phase length in ticks. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- wash_set  input  5  wash duration in ticks
- rinse_set  input  5  rinse duration in ticks
- spin_set  input  5  spin duration in ticks
- cloth_set  input  5  cloth load
- start  input  1  level, sampled each clk
- pause  input  1  level; freezes progress while high
- abort  input  1  level, sampled each clk
- ack  input  1  clears DONE
- door_open  input  1  door sensor; used only with WM_DOOR_INTERLOCK_EN
- state  output  3  IDLE=0, FILL=1, WASH=2, DRAIN=3, RINSE=4, SPIN=5, DONE=6
- remaining  output  8  ticks left in the whole programme
- valve_on  output  1  high in FILL and RINSE
- motor_on  output  1  high in WASH, RINSE and SPIN
- spin_fast  output  1  high in SPIN
- pump_on  output  1  high in DRAIN and SPIN
- door_lock  output  1  high in every state except IDLE and DONE
- done_pulse  output  1  one-cycle strobe on entry to DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, all latched settings=0, prescaler=0, phase counter=0, remaining=0.
  - All actuator outputs, door_lock and done_pulse = 0.
  - Reset mid-cycle returns to IDLE immediately; no drain is performed.
- Outputs are decoded from registered state only; no combinational path from any input.
- Start:
  - In IDLE, start=1 at edge N latches wash_set, rinse_set, spin_set and fill = cloth_set[4:2]+1 (range 1..8).
  - state=FILL from edge N+1; prescaler cleared.
  - start is ignored in every state other than IDLE.
- Tick generation:
  - The prescaler counts 0..TICK_DIV-1 only in active phases (FILL..SPIN) while pause=0.
  - tick = prescaler at TICK_DIV-1.
  - While paused, prescaler and phase counter hold and actuator outputs hold.
- Phase timing:
  - On phase entry the phase counter loads the phase duration.
  - Each tick decrements the counter; a tick with counter=1 advances to the next phase.
- Phase order: FILL(fill) -> WASH(wash) -> DRAIN(DRAIN_TICKS) -> RINSE(rinse) -> SPIN(spin) -> DONE.
  - WASH, RINSE or SPIN with latched duration 0 is skipped in the same transition; the next non-zero phase is entered directly.
  - FILL and DRAIN are never skipped.
  - Minimum programme is FILL 1 + DRAIN DRAIN_TICKS ticks.
- remaining:
  - Loaded at start with fill+wash+DRAIN_TICKS+rinse+spin.
  - Decrements by 1 on every tick; equals 0 in DONE and IDLE.
  - Maximum value 8+31+15+31+31=116, so no overflow.
- DONE:
  - done_pulse=1 for the single cycle of DONE entry.
  - state holds at DONE until ack=1, then IDLE next edge.
- Abort:
  - abort=1 in FILL, WASH, RINSE or SPIN: go to DRAIN next edge, phase counter=DRAIN_TICKS, remaining=DRAIN_TICKS.
  - After that DRAIN the block goes directly to DONE; done_pulse is still asserted.
  - abort in DRAIN, IDLE or DONE has no effect.
- Priority within one cycle: abort > pause > tick advance. An abort while paused is honoured.

Optional Feature:
- Macro: WM_DOOR_INTERLOCK_EN.
- When defined:
  - start in IDLE is ignored while door_open=1.
  - door_open=1 in any active phase acts as an internal pause, OR-ed with the pause input.
  - Progress resumes on the first cycle with door_open=0 and pause=0.
- When undefined: door_open is ignored entirely; behaviour is as above.

Test Plan:
- Full programme: TICK_DIV=4, DRAIN_TICKS=2, cloth=8, wash=2, rinse=1, spin=1, start pulse.
  -> FILL 3 ticks, WASH 2, DRAIN 2, RINSE 1, SPIN 1.
  -> remaining=9 at FILL entry; DONE reached 36 clk after FILL entry; done_pulse one cycle; ack returns to IDLE.
- Skip phases: wash=0, rinse=0, spin=0, cloth=0, start.
  -> FILL 1 tick -> DRAIN 2 ticks -> DONE after 12 clk; remaining=3 at start.
  -> motor_on never asserted.
- Pause: assert pause for 10 clk mid-WASH.
  -> state, remaining and prescaler frozen for those 10 clk; DONE is delayed by exactly 10 clk versus the unpaused run.
- Abort: abort in RINSE with 5 ticks remaining.
  -> DRAIN next edge, remaining=2, pump_on=1.
  -> DONE 8 clk later; SPIN never entered.
- Async reset: drop rst_n mid-SPIN, between clock edges.
  -> all outputs 0 immediately; after release, start is accepted normally.
- WM_DOOR_INTERLOCK_EN defined: start with door_open=1 -> stays IDLE.
  -> Then door_open=1 during FILL holds progress; releasing the door resumes.
  -> Total programme length grows by exactly the open duration.
